// File: rtl/timer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_arbiter_pkg
//  Description : Shared definitions for the shared countdown-timer arbiter:
//                FSM state encoding, the state enum and the minimum count
//                that a zero delay request is promoted to.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_arbiter_pkg;

    // State encoding of the arbiter FSM.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_DONE = DONE
    } state_e;

    // A requested delay of 0 is run as this many cycles, so every grant
    // lasts at least one cycle and always ends with a done pulse.
    localparam int unsigned c_MIN_COUNT = 1;

endpackage : timer_arbiter_pkg
`default_nettype wire

// File: rtl/timer_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : timer_arbiter_rr_pick
//  Description : Combinational round-robin picker. Scans the request vector
//                starting at last_i+1 and wrapping modulo NUM_REQ; the first
//                active request found wins.
//  Ports       : req_i      - level request per requester
//                last_i     - index of the previous winner
//                valid_o    - at least one request is active
//                winner_o   - index of the winner (0 when valid_o is low)
//                onehot_o   - one-hot form of winner_o (0 when valid_o is low)
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter_rr_pick
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   winner_o,
    output logic [NUM_REQ-1:0] onehot_o
);

    logic [IDX_W-1:0] w_cand;

    // Candidates are visited from the lowest priority (last_i itself) up to
    // the highest (last_i+1); each later hit overwrites the earlier one, so
    // the nearest active request after last_i is what remains.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        onehot_o = '0;
        w_cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
            if (req_i[w_cand]) begin
                valid_o          = 1'b1;
                winner_o         = w_cand;
                onehot_o         = '0;
                onehot_o[w_cand] = 1'b1;
            end
        end
    end

endmodule : timer_arbiter_rr_pick
`default_nettype wire

// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : timer_arbiter
//  Description : One programmable countdown timer shared round-robin by
//                NUM_REQ requesters. A requester holds a level request with
//                its delay; the winner owns the timer for max(delay,1) cycles
//                and then receives a one-cycle done pulse. Dropping the
//                request while owning the timer aborts the countdown silently.
//  Ports       : clk          - rising-edge clock
//                rst          - synchronous active-high reset
//                req_i        - level request per requester
//                req_count_i  - delay for requester i in
//                               [i*COUNT_WIDTH +: COUNT_WIDTH]
//                grant_o      - one-hot timer owner, zero when idle
//                done_o       - one-cycle expiry pulse to the owner
//                busy_o       - high while counting or signalling done
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_count_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [NUM_REQ-1:0]             done_o,
    output logic                           busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [COUNT_WIDTH-1:0] c_CNT_MIN = COUNT_WIDTH'(c_MIN_COUNT);
    localparam logic [IDX_W-1:0]       c_LAST_RST = IDX_W'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]        last_q,  last_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      done_q,  done_d;
    logic                    busy_q,  busy_d;

    // ------------------------------------------------------------------
    // Delay field unpacking and winner selection
    // ------------------------------------------------------------------
    logic [COUNT_WIDTH-1:0]  w_counts [NUM_REQ];
    logic                    w_pick_valid;
    logic [IDX_W-1:0]        w_pick_idx;
    logic [NUM_REQ-1:0]      w_pick_onehot;
    logic [COUNT_WIDTH-1:0]  w_win_count;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_count_unpack
        assign w_counts[gi] = req_count_i[gi*COUNT_WIDTH +: COUNT_WIDTH];
    end

    timer_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (req_i),
        .last_i   (last_q),
        .valid_o  (w_pick_valid),
        .winner_o (w_pick_idx),
        .onehot_o (w_pick_onehot)
    );

    assign w_win_count = w_counts[w_pick_idx];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                // The winner's delay is captured only here; later changes on
                // req_count_i have no effect on the running countdown.
                if (w_pick_valid) begin
                    state_d = S_RUN;
                    grant_d = w_pick_onehot;
                    cnt_d   = (w_win_count == '0) ? c_CNT_MIN : w_win_count;
                    last_d  = w_pick_idx;
                    busy_d  = 1'b1;
                end
            end

            S_RUN: begin
                // The owner's index is last_q for the whole grant. A dropped
                // request is checked before expiry so it wins on a tie.
                if (!req_i[last_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == c_CNT_MIN) begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                    grant_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                // Requests are ignored for this cycle; the IDLE cycle that
                // follows is where a still-raised request is re-arbitrated.
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= c_LAST_RST;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;

endmodule : timer_arbiter
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_arbiter
//  Description : Self-checking bench for timer_arbiter (NUM_REQ=4,
//                COUNT_WIDTH=16). A timeline reference model predicts grant,
//                done and busy every cycle from grant start times and
//                lengths; directed vectors and sequences add explicit checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_arbiter;

    localparam int N  = 4;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*CW-1:0] req_count;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;

    always #5 clk = ~clk;

    timer_arbiter #(
        .NUM_REQ     (N),
        .COUNT_WIDTH (CW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .req_count_i (req_count),
        .grant_o     (grant),
        .done_o      (done),
        .busy_o      (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: owner of the current/last grant, the cycle its grant
    // starts and how many cycles it lasts; done falls on start+len.
    int m_owner = -1;
    int m_start = 0;
    int m_len   = 0;
    int m_last  = N - 1;

    logic [N-1:0] exp_grant  = '0;
    logic [N-1:0] exp_done   = '0;
    logic         exp_busy   = 1'b0;
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] drop_next  = '0;

    int q_order[$];
    int q_rise[$];
    int q_fall[$];
    int q_done[$];

    typedef struct {
        int           idx;
        int           count;
        int           exp_len;
        logic [N-1:0] exp_onehot;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_ref(input logic [N-1:0] r, input int lst);
        for (int k = 1; k <= N; k++) begin
            if (r[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int count_of(input int i);
        return int'(req_count[i*CW +: CW]);
    endfunction

    task automatic post(input int i, input int c);
        req_count[i*CW +: CW] = CW'(c);
        req[i] = 1'b1;
    endtask

    // Advance one clock: update the model with the inputs of the current
    // cycle, take the edge, then compare the new cycle's outputs.
    task automatic tick();
        int w;
        if (rst) begin
            m_owner = -1;
            m_last  = N - 1;
        end else if (m_owner >= 0 && cyc >= m_start && cyc < m_start + m_len) begin
            if (!req[m_owner]) m_owner = -1;
        end else if (m_owner < 0 || cyc > m_start + m_len) begin
            w       = rr_ref(req, m_last);
            m_owner = w;
            if (w >= 0) begin
                m_start = cyc + 1;
                m_len   = (count_of(w) == 0) ? 1 : count_of(w);
                m_last  = w;
            end
        end

        @(posedge clk);
        #1;
        cyc++;

        exp_grant = '0;
        exp_done  = '0;
        exp_busy  = 1'b0;
        if (m_owner >= 0) begin
            if (cyc >= m_start && cyc < m_start + m_len) exp_grant[m_owner] = 1'b1;
            if (cyc == m_start + m_len) exp_done[m_owner] = 1'b1;
            exp_busy = (cyc >= m_start && cyc <= m_start + m_len);
        end
        chk("model_grant", 64'(grant), 64'(exp_grant));
        chk("model_done",  64'(done),  64'(exp_done));
        chk("model_busy",  64'(busy),  64'(exp_busy));

        if (grant != '0 && prev_grant == '0) begin
            q_order.push_back(idx_of(grant));
            q_rise.push_back(cyc);
        end
        if (grant == '0 && prev_grant != '0) q_fall.push_back(cyc);
        if (done != '0) q_done.push_back(idx_of(done));
        prev_grant = grant;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        req_count = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_q();
        q_order.delete();
        q_rise.delete();
        q_fall.delete();
        q_done.delete();
    endtask

    initial begin
        int g;
        int n;

        vecs[0] = '{1, 101, 101, 4'b0010};
        vecs[1] = '{3,   0,   1, 4'b1000};
        vecs[2] = '{0,   1,   1, 4'b0001};
        vecs[3] = '{2,   2,   2, 4'b0100};
        vecs[4] = '{0, 300, 300, 4'b0001};
        vecs[5] = '{3,  17,  17, 4'b1000};

        do_reset();
        chk("reset_grant", 64'(grant), 64'(0));
        chk("reset_done",  64'(done),  64'(0));
        chk("reset_busy",  64'(busy),  64'(0));

        // ---------------- single-requester vectors ----------------
        for (int v = 0; v < 6; v++) begin
            int lat;
            int len;
            post(vecs[v].idx, vecs[v].count);
            lat = 0;
            while (grant == '0 && lat < 8) begin
                tick();
                lat++;
            end
            chk("vec_latency", 64'(lat), 64'(1));
            chk("vec_grant", 64'(grant), 64'(vecs[v].exp_onehot));
            len = 0;
            while (grant != '0 && len < vecs[v].exp_len + 8) begin
                len++;
                tick();
            end
            chk("vec_len", 64'(len), 64'(vecs[v].exp_len));
            chk("vec_done", 64'(done), 64'(vecs[v].exp_onehot));
            chk("vec_busy_in_done", 64'(busy), 64'(1));
            req = '0;
            tick();
            chk("vec_busy_after", 64'(busy), 64'(0));
            chk("vec_done_after", 64'(done), 64'(0));
        end

        // ---------------- all four at once ----------------
        do_reset();
        clear_q();
        post(0, 5);
        post(1, 6);
        post(2, 7);
        post(3, 8);
        for (int t = 0; t < 200 && req != '0; t++) begin
            tick();
            req = req & ~done;
        end
        tick();
        chk("all4_ngrants", 64'(q_order.size()), 64'(4));
        if (q_order.size() == 4 && q_fall.size() == 4 && q_done.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("all4_order", 64'(q_order[k]), 64'(k));
                chk("all4_len", 64'(q_fall[k] - q_rise[k]), 64'(5 + k));
                chk("all4_done_idx", 64'(q_done[k]), 64'(k));
                if (k < 3) chk("all4_gap", 64'(q_rise[k+1] - q_fall[k]), 64'(2));
            end
        end

        // ---------------- two continuous requesters ----------------
        do_reset();
        clear_q();
        post(0, 3);
        post(2, 3);
        for (int t = 0; t < 100 && q_order.size() < 6; t++) tick();
        chk("alt_ngrants", 64'(q_order.size()), 64'(6));
        if (q_order.size() >= 6 && q_done.size() >= 5) begin
            for (int k = 0; k < 6; k++) chk("alt_order", 64'(q_order[k]), 64'((k % 2) * 2));
            for (int k = 0; k < 5; k++) chk("alt_done", 64'(q_done[k]), 64'((k % 2) * 2));
        end
        req = '0;
        tick();
        tick();

        // ---------------- abort in RUN cycle 50 ----------------
        do_reset();
        clear_q();
        post(3, 900);
        tick();
        chk("abort_grant3", 64'(grant), 64'(4'b1000));
        g = cyc;
        post(1, 4);
        while (cyc < g + 49) tick();
        req[3] = 1'b0;
        tick();
        chk("abort_grant_off", 64'(grant), 64'(0));
        chk("abort_busy_off",  64'(busy),  64'(0));
        tick();
        chk("abort_regrant1", 64'(grant), 64'(4'b0010));
        for (int t = 0; t < 20 && done == '0; t++) tick();
        chk("abort_done1", 64'(done), 64'(4'b0010));
        req = '0;
        tick();
        n = 0;
        foreach (q_done[k]) if (q_done[k] == 3) n++;
        chk("abort_no_done3", 64'(n), 64'(0));

        // ---------------- reset mid-RUN ----------------
        do_reset();
        clear_q();
        post(2, 101);
        tick();
        chk("rst_grant2", 64'(grant), 64'(4'b0100));
        g = cyc;
        post(1, 7);
        while (cyc < g + 19) tick();
        rst = 1'b1;
        tick();
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_done",  64'(done),  64'(0));
        chk("rst_busy",  64'(busy),  64'(0));
        rst = 1'b0;
        tick();
        chk("rst_regrant1", 64'(grant), 64'(4'b0010));
        for (int t = 0; t < 20 && done == '0; t++) tick();
        chk("rst_done1", 64'(done), 64'(4'b0010));
        req = '0;
        tick();
        n = 0;
        foreach (q_done[k]) if (q_done[k] == 2) n++;
        chk("rst_no_done2", 64'(n), 64'(0));

        // ---------------- randomized traffic ----------------
        do_reset();
        clear_q();
        drop_next = '0;
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (exp_done[i]) begin
                        if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                        else drop_next[i] = 1'b1;
                    end else if (drop_next[i]) begin
                        req[i]       = 1'b0;
                        drop_next[i] = 1'b0;
                    end else if (exp_grant[i] && $urandom_range(63, 0) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(7, 0) == 0) begin
                    if ($urandom_range(9, 0) == 0) post(i, int'($urandom_range(40, 0)));
                    else post(i, int'($urandom_range(12, 0)));
                end
            end
            tick();
        end
        chk("rand_activity", 64'(q_done.size() > 50), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_timer_arbiter
`default_nettype wire
